// File: rtl/cpu_pkg.sv
// Shared types and field constants for the LEGv8 fetch stage and datapath.
package cpu_pkg;

  // Fetch FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

  // Sequential PC increment in bytes
  localparam int INSTR_BYTES = 4;

  // Branch offset field positions inside an instruction word
  localparam int BR26_MSB = 25;  // B: imm26 = instr[25:0]
  localparam int CB19_MSB = 23;  // CBZ/B.cond: imm19 = instr[23:5]
  localparam int CB19_LSB = 5;

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction-memory bus between the fetch stage (master) and memory (slave).
//
// Handshake: the master raises imem_req with imem_addr and keeps both stable
// until the slave answers with imem_ack for exactly one cycle, in which
// imem_rdata holds the instruction. A transfer completes on any rising edge
// where imem_req and imem_ack are both 1; imem_ack at any other time is ignored.
interface instr_fetch_if #(
  parameter int ADDR_W  = 64,
  parameter int INSTR_W = 32
);
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/branch_target.sv
// Branch target adder: pc + (sign-extended offset << 2), offset taken from the
// 26-bit B field or the 19-bit CBZ/B.cond field. Purely combinational.
module branch_target
  import cpu_pkg::*;
#(
  parameter int ADDR_W  = 64,
  parameter int INSTR_W = 32
) (
  input  logic [ADDR_W-1:0]  pc_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic               uncond_br_i,
  output logic [ADDR_W-1:0]  target_o
);

  localparam int BR26_W = BR26_MSB + 1;
  localparam int CB19_W = CB19_MSB - CB19_LSB + 1;

  logic [ADDR_W-1:0] off26_se;
  logic [ADDR_W-1:0] off19_se;
  logic [ADDR_W-1:0] off_se;

  // Opcode and Rt bits are not part of either offset field
  logic unused_instr_bits;
  assign unused_instr_bits = ^{instr_i[INSTR_W-1:BR26_MSB+1], instr_i[CB19_LSB-1:0]};

  assign off26_se = {{(ADDR_W-BR26_W){instr_i[BR26_MSB]}}, instr_i[BR26_MSB:0]};
  assign off19_se = {{(ADDR_W-CB19_W){instr_i[CB19_MSB]}}, instr_i[CB19_MSB:CB19_LSB]};

  // Select offset field and form the word-aligned target (wraps modulo 2^ADDR_W)
  always_comb begin
    off_se   = uncond_br_i ? off26_se : off19_se;
    target_o = pc_i + (off_se << 2);
  end

endmodule

// File: rtl/instr_fetch.sv
// LEGv8 fetch stage: owns the PC, fetches one instruction at a time over the
// imem req/ack bus and holds it (instr/pc/instr_valid) until execute accepts
// it with instr_ready, then advances the PC to pc+4 or the branch target.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int               ADDR_W   = 64,
  parameter int               INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  instr_fetch_if.master      imem,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [ADDR_W-1:0]  pc,
  input  logic               BrTaken,
  input  logic               UncondBr,
  output fetch_state_t       state_dbg
);

  fetch_state_t       state_q;
  logic [ADDR_W-1:0]  pc_q;
  logic [INSTR_W-1:0] instr_q;
  logic               req_q;
  logic               valid_q;

  logic [ADDR_W-1:0]  target;
  logic [ADDR_W-1:0]  next_pc_d;

  branch_target #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_branch_target (
    .pc_i        (pc_q),
    .instr_i     (instr_q),
    .uncond_br_i (UncondBr),
    .target_o    (target)
  );

  // Next PC: a not-taken branch selects pc+4 regardless of UncondBr
  always_comb begin
    next_pc_d = pc_q + ADDR_W'(INSTR_BYTES);
    if (BrTaken) begin
      next_pc_d = target;
    end
  end

  // Fetch FSM with registered req/valid outputs; BrTaken/UncondBr only matter on accept
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q <= REQ;
          req_q   <= 1'b1;
        end
        REQ: begin
          if (imem.imem_ack) begin
            instr_q <= imem.imem_rdata;
            state_q <= HOLD;
            req_q   <= 1'b0;
            valid_q <= 1'b1;
          end
        end
        HOLD: begin
          if (instr_ready) begin
            pc_q    <= next_pc_d;
            state_q <= REQ;
            req_q   <= 1'b1;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc_q;
  assign instr          = instr_q;
  assign instr_valid    = valid_q;
  assign pc             = pc_q;
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed testbench for instr_fetch: sequential fetches, B/CBZ targets,
// memory stalls, execute back-pressure, reset mid-request and PC wrap-around.
module tb_instr_fetch;
  import cpu_pkg::*;

  localparam int ADDR_W  = 64;
  localparam int INSTR_W = 32;

  localparam logic [31:0] NOP    = 32'hD503201F;
  localparam logic [31:0] B_P3   = 32'h14000003;  // B #3
  localparam logic [31:0] B_M1   = 32'h17FFFFFF;  // B #-1
  localparam logic [31:0] CBZ_M2 = 32'hB4FFFFC0;  // CBZ imm19=-2
  localparam logic [31:0] JUNK   = 32'hDEADBEEF;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic               instr_ready;
  logic               br_taken;
  logic               uncond_br;
  logic [INSTR_W-1:0] instr;
  logic               instr_valid;
  logic [ADDR_W-1:0]  pc;
  fetch_state_t       state_dbg;

  instr_fetch_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) imem_bus ();

  instr_fetch #(
    .ADDR_W   (ADDR_W),
    .INSTR_W  (INSTR_W),
    .RESET_PC ('0)
  ) dut (
    .clk         (clk),
    .reset       (rst),
    .imem        (imem_bus),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .pc          (pc),
    .BrTaken     (br_taken),
    .UncondBr    (uncond_br),
    .state_dbg   (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [ADDR_W-1:0] exp_q[$];  // expected fetch addresses, in order

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance one clock; inputs are changed and outputs sampled 1ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete fetch starting in REQ: ack_wait idle cycles before ack,
  // ready_wait cycles of back-pressure (with stray acks) before accept.
  task automatic do_fetch(input logic [31:0] word, input int ack_wait, input int ready_wait,
                          input logic br, input logic unc);
    logic [ADDR_W-1:0] exp_pc;
    exp_pc = exp_q.pop_front();
    check("req_in_REQ", 64'(imem_bus.imem_req), 64'd1);
    check("addr_in_REQ", imem_bus.imem_addr, exp_pc);
    check("valid_in_REQ", 64'(instr_valid), 64'd0);
    for (int i = 0; i < ack_wait; i++) begin
      imem_bus.imem_ack   = 1'b0;
      imem_bus.imem_rdata = JUNK;
      instr_ready         = 1'b1;  // ready without valid must be ignored
      step();
      check("stall_req", 64'(imem_bus.imem_req), 64'd1);
      check("stall_addr", imem_bus.imem_addr, exp_pc);
      check("stall_valid", 64'(instr_valid), 64'd0);
      check("stall_state", 64'(state_dbg), 64'(REQ));
    end
    instr_ready         = (ready_wait == 0);
    br_taken            = br;
    uncond_br           = unc;
    imem_bus.imem_ack   = 1'b1;
    imem_bus.imem_rdata = word;
    step();
    imem_bus.imem_ack   = 1'b0;
    imem_bus.imem_rdata = JUNK;
    check("hold_valid", 64'(instr_valid), 64'd1);
    check("hold_instr", 64'(instr), 64'(word));
    check("hold_pc", pc, exp_pc);
    check("hold_req", 64'(imem_bus.imem_req), 64'd0);
    for (int i = 0; i < ready_wait; i++) begin
      imem_bus.imem_ack = 1'(i % 2 == 0);  // stray acks while holding
      instr_ready       = 1'b0;
      br_taken          = 1'b1;
      uncond_br         = 1'b1;
      step();
      check("bp_instr", 64'(instr), 64'(word));
      check("bp_pc", pc, exp_pc);
      check("bp_state", 64'(state_dbg), 64'(HOLD));
      check("bp_valid", 64'(instr_valid), 64'd1);
    end
    imem_bus.imem_ack = 1'b0;
    instr_ready       = 1'b1;
    br_taken          = br;
    uncond_br         = unc;
    step();
    instr_ready = 1'b0;
    br_taken    = 1'b0;
    uncond_br   = 1'b0;
    check("accept_state", 64'(state_dbg), 64'(REQ));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst                 = 1'b1;
    instr_ready         = 1'b0;
    br_taken            = 1'b0;
    uncond_br           = 1'b0;
    imem_bus.imem_ack   = 1'b0;
    imem_bus.imem_rdata = '0;
    step();
    step();
    check("rst_state", 64'(state_dbg), 64'(IDLE));
    check("rst_pc", pc, 64'd0);
    check("rst_instr", 64'(instr), 64'd0);
    check("rst_req", 64'(imem_bus.imem_req), 64'd0);
    check("rst_valid", 64'(instr_valid), 64'd0);

    rst = 1'b0;
    step();  // IDLE -> REQ

    // Expected fetch addresses, hand computed
    exp_q = '{64'h0, 64'h4, 64'h8, 64'hC, 64'h10, 64'h1C, 64'h20, 64'h18, 64'h1C, 64'h20};

    // Zero-latency sequential fetches
    do_fetch(NOP, 0, 0, 1'b0, 1'b0);   // 0x0  -> 0x4
    do_fetch(NOP, 0, 0, 1'b0, 1'b0);   // 0x4  -> 0x8
    do_fetch(NOP, 0, 0, 1'b0, 1'b0);   // 0x8  -> 0xC
    do_fetch(NOP, 0, 0, 1'b0, 1'b0);   // 0xC  -> 0x10
    // B #3 taken: 0x10 + 12
    do_fetch(B_P3, 0, 0, 1'b1, 1'b1);  // 0x10 -> 0x1C
    // Not taken with UncondBr=1 must still give pc+4
    do_fetch(NOP, 0, 0, 1'b0, 1'b1);   // 0x1C -> 0x20
    // CBZ -2 taken: 0x20 - 8
    do_fetch(CBZ_M2, 0, 0, 1'b1, 1'b0); // 0x20 -> 0x18
    do_fetch(NOP, 0, 0, 1'b0, 1'b0);   // 0x18 -> 0x1C
    // Memory stall: ack withheld 5 cycles
    do_fetch(NOP, 5, 0, 1'b0, 1'b0);   // 0x1C -> 0x20
    // CBZ not taken under 4 cycles of back-pressure with stray acks
    do_fetch(CBZ_M2, 0, 4, 1'b0, 1'b0); // 0x20 -> 0x24

    // Reset mid-REQ with a coincident ack
    check("pre_rst_addr", imem_bus.imem_addr, 64'h24);
    imem_bus.imem_ack   = 1'b1;
    imem_bus.imem_rdata = JUNK;
    rst                 = 1'b1;
    #1;
    check("async_rst_pc", pc, 64'd0);
    check("async_rst_req", 64'(imem_bus.imem_req), 64'd0);
    check("async_rst_valid", 64'(instr_valid), 64'd0);
    step();
    check("rst_ack_discard", 64'(instr), 64'd0);
    check("rst_ack_state", 64'(state_dbg), 64'(IDLE));
    imem_bus.imem_ack = 1'b0;
    rst               = 1'b0;
    step();
    check("refetch_state", 64'(state_dbg), 64'(REQ));

    // Wrap-around: B #-1 from 0 then pc+4 back to 0
    exp_q.push_back(64'h0);
    exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFC);
    do_fetch(B_M1, 0, 0, 1'b1, 1'b1);  // 0x0 -> 0x..FFFC
    do_fetch(NOP, 0, 0, 1'b0, 1'b0);   // 0x..FFFC -> 0x0
    check("wrap_addr", imem_bus.imem_addr, 64'h0);
    check("wrap_req", 64'(imem_bus.imem_req), 64'd1);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
